// File: rtl/reg_cmd_pkg.sv
// rtl/reg_cmd_pkg.sv - shared types and constants for the register command bridge
// Contents:
//   state_t         bridge FSM states
//   CMD_* params    command byte field positions
//   DATA_*          register data width and byte count
//   cmd_rsvd_ok()   true when the reserved command bits are all zero
package reg_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 4;

    localparam int DATA_BYTES = 4;
    localparam int DATA_WIDTH = 32;

    function automatic logic cmd_rsvd_ok(input logic [7:0] cmd);
        return cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0;
    endfunction

endpackage

// File: rtl/reg_resp_serializer.sv
// rtl/reg_resp_serializer.sv - shifts a 32-bit read word out as 4 bytes, MSB first
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_data and start presenting bytes
//   load_data    32-bit word to send
//   out_data     current byte (MSB of the shift register)
//   out_valid    byte available
//   out_ready    host accepts byte
//   done         high in the cycle of the final byte handshake
module reg_resp_serializer
    import reg_cmd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done
);

    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [1:0]            sent_cnt;

    assign out_data = shreg[DATA_WIDTH-1 -: 8];

    // Combinational so the bridge can leave RESP on the same edge that
    // completes the last handshake.
    assign done = out_valid && out_ready && (sent_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            sent_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            shreg     <= load_data;
            sent_cnt  <= '0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            shreg    <= {shreg[DATA_WIDTH-9:0], 8'h00};
            sent_cnt <= sent_cnt + 2'd1;
            if (sent_cnt == LAST_BYTE) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_bridge.sv
// rtl/reg_cmd_bridge.sv - byte-stream command parser driving a 16x32 register block
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    host command byte stream
//   out_data/out_valid/out_ready read response byte stream (4 bytes, MSB first)
//   reg_data_out, reg_addr_out   write data / address to register block (held)
//   reg_wr_out, reg_rd_out       one-cycle write / read strobes
//   reg_rdata_in, reg_rvalid_in  read data returned by register block
//   err_out                      one-cycle pulse on bad command or timeout
//   busy_out                     high whenever the FSM is not idle
module reg_cmd_bridge
    import reg_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [ADDR_WIDTH-1:0] reg_addr_out,
    output logic                  reg_wr_out,
    output logic                  reg_rd_out,
    input  logic [DATA_WIDTH-1:0] reg_rdata_in,
    input  logic                  reg_rvalid_in,
    output logic                  err_out,
    output logic                  busy_out
);

    localparam int         TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_sr;
    logic [1:0]            byte_cnt;
    logic [TW-1:0]         idle_cnt;
    logic                  resp_load;
    logic                  resp_done;

    assign in_ready  = (state == ST_IDLE) || (state == ST_WDATA);
    assign busy_out  = (state != ST_IDLE);
    assign resp_load = (state == ST_RD_WAIT) && reg_rvalid_in;

    // Write data is assembled in wdata_sr and only copied to reg_data_out
    // when the frame completes, so an aborted frame never disturbs the
    // value presented to the register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wdata_sr     <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            reg_data_out <= '0;
            reg_addr_out <= '0;
            reg_wr_out   <= 1'b0;
            reg_rd_out   <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            reg_wr_out <= 1'b0;
            reg_rd_out <= 1'b0;
            err_out    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (in_valid) begin
                        if (!cmd_rsvd_ok(in_data)) begin
                            err_out <= 1'b1;
                        end else begin
                            reg_addr_out <= in_data[ADDR_WIDTH-1:0];
                            byte_cnt     <= '0;
                            wdata_sr     <= '0;
                            if (in_data[CMD_WR_BIT]) begin
                                state <= ST_WDATA;
                            end else begin
                                state      <= ST_RD_REQ;
                                reg_rd_out <= 1'b1;
                            end
                        end
                    end
                end

                ST_WDATA: begin
                    if (in_valid) begin
                        idle_cnt <= '0;
                        wdata_sr <= {wdata_sr[DATA_WIDTH-9:0], in_data};
                        if (byte_cnt == LAST_BYTE) begin
                            reg_data_out <= {wdata_sr[DATA_WIDTH-9:0], in_data};
                            reg_wr_out   <= 1'b1;
                            state        <= ST_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= ST_IDLE;
                        err_out  <= 1'b1;
                        wdata_sr <= '0;
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_WRITE: begin
                    state <= ST_IDLE;
                end

                ST_RD_REQ: begin
                    idle_cnt <= '0;
                    state    <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (reg_rvalid_in) begin
                        idle_cnt <= '0;
                        state    <= ST_RESP;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state    <= ST_IDLE;
                        err_out  <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (resp_done) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_resp_serializer u_resp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (resp_load),
        .load_data (reg_rdata_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (resp_done)
    );

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// tb/tb_reg_cmd_bridge.sv - directed self-checking bench for reg_cmd_bridge
module tb_reg_cmd_bridge;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] reg_data_out;
    logic [3:0]  reg_addr_out;
    logic        reg_wr_out;
    logic        reg_rd_out;
    logic [31:0] reg_rdata_in;
    logic        reg_rvalid_in;
    logic        err_out;
    logic        busy_out;

    int n_cmp;
    int n_bad;
    int wr_cnt;
    int rd_cnt;
    int err_cnt;

    reg_cmd_bridge #(
        .ADDR_WIDTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .reg_data_out  (reg_data_out),
        .reg_addr_out  (reg_addr_out),
        .reg_wr_out    (reg_wr_out),
        .reg_rd_out    (reg_rd_out),
        .reg_rdata_in  (reg_rdata_in),
        .reg_rvalid_in (reg_rvalid_in),
        .err_out       (err_out),
        .busy_out      (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_out) wr_cnt++;
        if (reg_rd_out) rd_cnt++;
        if (err_out)    err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
        return 8'((w >> (24 - 8 * idx)) & 32'hFF);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Issues a read command and plays the register block; returns in cycle N+3.
    task automatic do_read(input logic [7:0] cmd, input logic [31:0] rdata);
        send_byte(cmd);
        chk("rd_strobe_n1", {31'd0, reg_rd_out}, 32'd1);
        chk("rd_addr", {28'd0, reg_addr_out}, {28'd0, cmd[3:0]});
        chk("rd_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rd_strobe_n2", {31'd0, reg_rd_out}, 32'd0);
        chk("rd_no_early_valid", {31'd0, out_valid}, 32'd0);
        reg_rdata_in  = rdata;
        reg_rvalid_in = 1'b1;
        tick();
        reg_rvalid_in = 1'b0;
        reg_rdata_in  = 32'h0;
        chk("rd_valid_n3", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input logic [31:0] w);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_byte", {24'd0, out_data}, {24'd0, byte_of(w, i)});
            tick();
        end
        out_ready = 1'b0;
        chk("drain_end_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_end_busy", {31'd0, busy_out}, 32'd0);
        chk("drain_end_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [31:0] wdata);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) begin
            send_byte(byte_of(wdata, i));
        end
        chk("wr_strobe_n1", {31'd0, reg_wr_out}, 32'd1);
        chk("wr_addr", {28'd0, reg_addr_out}, {28'd0, cmd[3:0]});
        chk("wr_data", reg_data_out, wdata);
        chk("wr_in_ready_n1", {31'd0, in_ready}, 32'd0);
        tick();
        chk("wr_strobe_n2", {31'd0, reg_wr_out}, 32'd0);
        chk("wr_in_ready_n2", {31'd0, in_ready}, 32'd1);
        chk("wr_busy_n2", {31'd0, busy_out}, 32'd0);
    endtask

    initial begin
        int          wr0;
        int          rd0;
        int          err0;
        int          idx;
        int          c;
        logic [3:0]  pat;
        logic [31:0] w;

        n_cmp = 0; n_bad = 0;
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        in_data = 8'h00; in_valid = 1'b0;
        out_ready = 1'b0;
        reg_rdata_in = 32'h0; reg_rvalid_in = 1'b0;

        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_addr", {28'd0, reg_addr_out}, 32'd0);
        chk("rst_data", reg_data_out, 32'd0);
        chk("rst_err", {31'd0, err_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Write to addr 5
        err0 = err_cnt;
        do_write(8'h85, 32'hDEADBEEF);
        chk("wr1_no_err", err_cnt, err0);
        chk("wr1_wr_count", wr_cnt, 1);

        // Stray rvalid in IDLE is ignored
        reg_rdata_in = 32'hFFFFFFFF; reg_rvalid_in = 1'b1;
        tick();
        reg_rvalid_in = 1'b0; reg_rdata_in = 32'h0;
        tick();
        chk("stray_rvalid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_rvalid_busy", {31'd0, busy_out}, 32'd0);

        // Read addr 5
        do_read(8'h05, 32'h12345678);
        chk("rd1_data_held", reg_data_out, 32'hDEADBEEF);
        drain(32'h12345678);

        // Read with backpressure 1-0-0-1
        w = 32'hA1B2C3D4;
        do_read(8'h09, w);
        pat = 4'b1001;
        idx = 0;
        c = 0;
        while (idx < 4 && c < 16) begin
            out_ready = pat[3 - (c % 4)];
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_byte", {24'd0, out_data}, {24'd0, byte_of(w, idx)});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            if (out_ready) idx++;
            c++;
        end
        out_ready = 1'b0;
        chk("bp_bytes", idx, 4);
        chk("bp_cycles", c, 8);
        chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_end_in_ready", {31'd0, in_ready}, 32'd1);

        // Reserved bit set -> dropped with error
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
        send_byte(8'h95);
        chk("rsvd_err_pulse", {31'd0, err_out}, 32'd1);
        chk("rsvd_busy", {31'd0, busy_out}, 32'd0);
        chk("rsvd_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rsvd_addr_kept", {28'd0, reg_addr_out}, 32'd9);
        tick();
        chk("rsvd_err_one_cycle", {31'd0, err_out}, 32'd0);
        chk("rsvd_no_wr", wr_cnt, wr0);
        chk("rsvd_no_rd", rd_cnt, rd0);
        chk("rsvd_err_count", err_cnt, err0 + 1);
        do_read(8'h03, 32'hA5C30F81);
        drain(32'hA5C30F81);

        // Partial write then timeout (TIMEOUT_CYCLES = 8)
        wr0 = wr_cnt; err0 = err_cnt;
        send_byte(8'h82);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet_busy", {31'd0, busy_out}, 32'd1);
        chk("to_not_yet_err", {31'd0, err_out}, 32'd0);
        tick();
        chk("to_err_pulse", {31'd0, err_out}, 32'd1);
        chk("to_busy", {31'd0, busy_out}, 32'd0);
        chk("to_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("to_err_one_cycle", {31'd0, err_out}, 32'd0);
        chk("to_no_wr", wr_cnt, wr0);
        chk("to_err_count", err_cnt, err0 + 1);
        do_write(8'h82, 32'h01020304);

        // Reset in the middle of a response
        wr0 = wr_cnt;
        do_read(8'h07, 32'hCAFEF00D);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("mid_resp_byte", {24'd0, out_data}, 32'h000000F0);
        chk("mid_resp_busy", {31'd0, busy_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy_out}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_addr", {28'd0, reg_addr_out}, 32'd0);
        chk("arst_data", reg_data_out, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(8'h04, 32'h0BADC0DE);
        drain(32'h0BADC0DE);
        chk("arst_no_wr", wr_cnt, wr0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
